// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Execute-stage HI/LO unit. Captures or accumulates the ALU's 2*WIDTH-bit
//   product, accepts MTHI/MTLO writes, and runs a radix-2 restoring divide
//   (one quotient bit per cycle). Busy tells the hazard unit to stall.
// Ports
//   Clk        clock, all state updates on rising edge
//   Rst        synchronous active-high reset
//   Start      operation valid this cycle (ignored while Busy)
//   Op         000 NOP, 001 WRMUL, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO,
//              110 DIV, 111 DIVU
//   A, B       rs / rt operands
//   ProdLo/Hi  low / high product words from the ALU
//   Busy       divide in progress
//   Hi, Lo     architectural HI / LO registers
//   DivByZero  one-cycle pulse after a divide accepted with B == 0
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] ProdLo,
    input  logic [WIDTH-1:0] ProdHi,
    output logic             Busy,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DIV  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_WRMUL = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MSUB  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_DIV   = 3'b110;
    localparam logic [2:0] OP_DIVU  = 3'b111;

    logic [1:0]       state;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;
    logic [WIDTH-1:0] dvd;    // dividend shifts out MSB first, quotient shifts in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;

    logic             is_signed;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             fits;

    always_comb begin
        is_signed = (Op == OP_DIV);
        a_abs     = (is_signed && A[WIDTH-1]) ? -A : A;
        b_abs     = (is_signed && B[WIDTH-1]) ? -B : B;
        rem_sh    = {rem, dvd[WIDTH-1]};
        rem_sub   = rem_sh - {1'b0, dvs};
        // rem < dvs, so a borrow always shows up in the extra top bit
        fits      = ~rem_sub[WIDTH];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            dbz_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_WRMUL: {hi_q, lo_q} <= {ProdHi, ProdLo};
                            OP_MADD:  {hi_q, lo_q} <= {hi_q, lo_q} + {ProdHi, ProdLo};
                            OP_MSUB:  {hi_q, lo_q} <= {hi_q, lo_q} - {ProdHi, ProdLo};
                            OP_MTHI:  hi_q <= A;
                            OP_MTLO:  lo_q <= A;
                            OP_DIV, OP_DIVU: begin
                                if (B == '0) begin
                                    lo_q  <= '1;
                                    hi_q  <= A;
                                    dbz_q <= 1'b1;
                                end else begin
                                    dvd   <= a_abs;
                                    dvs   <= b_abs;
                                    rem   <= '0;
                                    cnt   <= '0;
                                    q_neg <= is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                                    r_neg <= is_signed && A[WIDTH-1];
                                    state <= DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                DIV: begin
                    rem <= fits ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], fits};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo_q  <= q_neg ? -dvd : dvd;
                    hi_q  <= r_neg ? -rem : rem;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = (state != IDLE);
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign DivByZero = dbz_q;

endmodule
